// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter
// Description : Round-robin arbiter with one-hot registered grant, owner
//               release, request-drop exit and an optional hold timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [WIDTH-1:0]                        request,
    input  logic [WIDTH-1:0]                        release_req,
    output logic [WIDTH-1:0]                        grant,
    output logic                                    grant_valid,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] grant_encoded,
    output logic                                    timeout_err
);

    localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [c_CNT_W-1:0] c_LIMIT   = c_CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [WIDTH-1:0]   c_ONE     = WIDTH'(1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(WIDTH - 1);

    localparam logic [0:0] c_S_ARB  = 1'b0;
    localparam logic [0:0] c_S_HOLD = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_grant;
    logic [c_IDX_W-1:0] r_grant_encoded;
    logic               r_grant_valid;
    logic               r_timeout_err;
    logic [c_CNT_W-1:0] r_count;
    logic [c_IDX_W-1:0] r_last_idx;

    logic [WIDTH-1:0]   w_upper;
    logic [WIDTH-1:0]   w_masked;
    logic [WIDTH-1:0]   w_sel_src;
    logic [c_IDX_W-1:0] w_win_idx;
    logic [WIDTH-1:0]   w_win_onehot;
    logic               w_owner_rel;
    logic               w_owner_req;
    logic               w_timeout;

    // Positions strictly above the last winner get first pick.
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_upper
            assign w_upper[g] = (r_last_idx < c_IDX_W'(g));
        end
    endgenerate

    always_comb begin
        w_masked  = request & w_upper;
        w_sel_src = (|w_masked) ? w_masked : request;
        w_win_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_sel_src[i]) begin
                w_win_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_win_onehot = c_ONE << w_win_idx;

    // Owner-only views; any non-owner bits are masked by the held grant.
    assign w_owner_rel = |(release_req & r_grant);
    assign w_owner_req = |(request & r_grant);
    assign w_timeout   = (TIMEOUT > 0) && (r_count == c_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_S_ARB;
            r_grant         <= '0;
            r_grant_encoded <= '0;
            r_grant_valid   <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_count         <= '0;
            r_last_idx      <= c_LAST_RST;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                c_S_ARB: begin
                    if (|request) begin
                        r_state         <= c_S_HOLD;
                        r_grant         <= w_win_onehot;
                        r_grant_encoded <= w_win_idx;
                        r_grant_valid   <= 1'b1;
                        r_last_idx      <= w_win_idx;
                        r_count         <= '0;
                    end
                end
                c_S_HOLD: begin
                    if (w_owner_rel || !w_owner_req || w_timeout) begin
                        r_state         <= c_S_ARB;
                        r_grant         <= '0;
                        r_grant_encoded <= '0;
                        r_grant_valid   <= 1'b0;
                        // A release in the limit cycle wins over the timeout.
                        r_timeout_err   <= w_timeout && !w_owner_rel;
                    end else if (r_count != c_CNT_MAX) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state         <= c_S_ARB;
                    r_grant         <= '0;
                    r_grant_encoded <= '0;
                    r_grant_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_encoded = r_grant_encoded;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_robin_arbiter
// Description : Directed scoreboard bench for round_robin_arbiter (4 ports,
//               4-cycle timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_robin_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] request = '0;
    logic [3:0] rel = '0;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_encoded;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] grant;
        logic       to;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    round_robin_arbiter #(
        .WIDTH   (4),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .request       (request),
        .release_req   (rel),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_encoded (grant_encoded),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, record the expected post-edge outputs,
    // then compare them against the DUT just after the edge.
    task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] rl,
                       input logic [3:0] exp_grant, input logic exp_to);
        exp_t e;
        request = req;
        rel     = rl;
        sb_q.push_back('{grant: exp_grant, to: exp_to, tag: tag});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".grant"}, 32'(grant), 32'(e.grant));
        check({e.tag, ".valid"}, 32'(grant_valid), 32'(|e.grant));
        check({e.tag, ".enc"},   32'(grant_encoded), 32'(idx_of(e.grant)));
        check({e.tag, ".to"},    32'(timeout_err), 32'(e.to));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.grant", 32'(grant), 32'h0);
        check("rst.valid", 32'(grant_valid), 32'h0);
        check("rst.enc",   32'(grant_encoded), 32'h0);
        check("rst.to",    32'(timeout_err), 32'h0);
        rst_n = 1'b1;

        // Fairness from reset: last_idx starts at 3, so index 0 goes first.
        cyc("fair0a", 4'b1111, 4'b0000, 4'b0001, 1'b0);
        cyc("fair0b", 4'b1111, 4'b0000, 4'b0001, 1'b0);
        cyc("fair0r", 4'b1111, 4'b0001, 4'b0000, 1'b0);
        cyc("fair1a", 4'b1111, 4'b0000, 4'b0010, 1'b0);
        cyc("fair1n", 4'b0110, 4'b1101, 4'b0010, 1'b0);
        cyc("fair1r", 4'b1111, 4'b0010, 4'b0000, 1'b0);
        cyc("fair2a", 4'b1111, 4'b0000, 4'b0100, 1'b0);
        cyc("fair2b", 4'b1111, 4'b0000, 4'b0100, 1'b0);
        cyc("fair2r", 4'b1111, 4'b0100, 4'b0000, 1'b0);
        cyc("fair3a", 4'b1111, 4'b0000, 4'b1000, 1'b0);
        cyc("fair3b", 4'b1111, 4'b0000, 4'b1000, 1'b0);
        cyc("fair3r", 4'b1111, 4'b1000, 4'b0000, 1'b0);
        cyc("fair4a", 4'b1111, 4'b0000, 4'b0001, 1'b0);
        cyc("fair4r", 4'b1111, 4'b0001, 4'b0000, 1'b0);

        // Single requester, idle, and release ignored in ARB (last_idx=0)
        cyc("single",  4'b0100, 4'b0000, 4'b0100, 1'b0);
        cyc("singler", 4'b0100, 4'b0100, 4'b0000, 1'b0);
        cyc("idle",    4'b0000, 4'b0000, 4'b0000, 1'b0);
        cyc("arbrel",  4'b0000, 4'b1111, 4'b0000, 1'b0);

        // Wrap (last_idx=2) then skip ahead
        cyc("wrap",    4'b0011, 4'b0000, 4'b0001, 1'b0);
        cyc("wrapr",   4'b0011, 4'b0001, 4'b0000, 1'b0);
        cyc("skip1",   4'b1010, 4'b0000, 4'b0010, 1'b0);
        cyc("skip1r",  4'b1010, 4'b0010, 4'b0000, 1'b0);
        cyc("skip3",   4'b1010, 4'b0000, 4'b1000, 1'b0);
        cyc("skip3r",  4'b1010, 4'b1000, 4'b0000, 1'b0);

        // Owner request drops mid-hold (last_idx=3 -> wraps to 0)
        cyc("drop",    4'b0001, 4'b0000, 4'b0001, 1'b0);
        cyc("dropx",   4'b1000, 4'b0000, 4'b0000, 1'b0);
        cyc("dropidl", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Timeout: grant held exactly 4 cycles, then one-cycle pulse
        cyc("to_h0",   4'b0010, 4'b0000, 4'b0010, 1'b0);
        cyc("to_h1",   4'b0010, 4'b0000, 4'b0010, 1'b0);
        cyc("to_h2",   4'b0010, 4'b0000, 4'b0010, 1'b0);
        cyc("to_h3",   4'b0010, 4'b0000, 4'b0010, 1'b0);
        cyc("to_exit", 4'b0010, 4'b0000, 4'b0000, 1'b1);
        cyc("to_regr", 4'b0010, 4'b0000, 4'b0010, 1'b0);

        // Release in the limit cycle suppresses the timeout pulse
        cyc("rl_h1",   4'b0010, 4'b0000, 4'b0010, 1'b0);
        cyc("rl_h2",   4'b0010, 4'b0000, 4'b0010, 1'b0);
        cyc("rl_h3",   4'b0010, 4'b0000, 4'b0010, 1'b0);
        cyc("rl_rel",  4'b0010, 4'b0010, 4'b0000, 1'b0);
        cyc("rl_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Asynchronous reset mid-hold (last_idx=1 -> index 3 wins)
        cyc("ar_grant", 4'b1000, 4'b0000, 4'b1000, 1'b0);
        rst_n = 1'b0;
        #2;
        check("ar.grant", 32'(grant), 32'h0);
        check("ar.valid", 32'(grant_valid), 32'h0);
        check("ar.enc",   32'(grant_encoded), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("ar_first", 4'b1010, 4'b0000, 4'b0010, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
